spi_command_sequencer: RTL and testbench

- Command front-end between the SPI secondary byte interface and the motion-segment FIFO.
- Decodes the first byte of each chip-select frame as a command and assembles incoming segment bytes into whole records.
- Commits a record to the FIFO only when it is complete and a free slot exists, so a torn or partial record never reaches the step generator.
- Supplies the byte the SPI secondary shifts out next (free-slot count or status word).

---
 rtl/spi_command_sequencer.sv | 153 +++++++++++++++
 tb/tb_spi_command_sequencer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_command_sequencer.sv
// SPI command front-end: decodes the frame command byte, assembles motion
// segment records and commits whole records to the segment FIFO.
module spi_command_sequencer #(
  parameter int unsigned RecordWords = 4,
  parameter int unsigned CountWidth  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_cs,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  input  logic [7:0]            fifo_free_slots,
  output logic                  fifo_write_en,
  output logic [7:0]            fifo_data,
  output logic [CountWidth-1:0] overrun_count,
  output logic                  busy
);

  // idx addresses the buffer; wr_idx must also reach RecordWords to mark the end of a commit
  localparam int unsigned IdxW   = $clog2(RecordWords);
  localparam int unsigned WrW    = $clog2(RecordWords + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(RecordWords - 1);
  localparam logic [WrW-1:0]  RecLen  = WrW'(RecordWords);
  localparam logic [7:0] CmdStatus = 8'd1;
  localparam logic [7:0] CmdWrite  = 8'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STAT,
    S_COLLECT,
    S_COMMIT
  } state_t;

  state_t          state;
  logic [7:0]      rec_buf [RecordWords];
  logic [IdxW-1:0] idx;
  logic [WrW-1:0]  wr_idx;
  logic            cs_pend;
  logic            st_overrun;
  logic            st_fragment;
  logic            st_proto;

  // Command decode, record assembly, commit sequencing and status reply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      idx           <= '0;
      wr_idx        <= '0;
      cs_pend       <= 1'b0;
      st_overrun    <= 1'b0;
      st_fragment   <= 1'b0;
      st_proto      <= 1'b0;
      tx_data       <= 8'h00;
      fifo_write_en <= 1'b0;
      fifo_data     <= 8'h00;
      overrun_count <= '0;
      busy          <= 1'b0;
      for (int i = 0; i < int'(RecordWords); i++) rec_buf[i] <= 8'h00;
    end else begin
      fifo_write_en <= 1'b0;
      case (state)
        S_IDLE: begin
          tx_data <= fifo_free_slots;
          idx     <= '0;
          if (!spi_cs && rx_valid) begin
            if (rx_data == CmdWrite) begin
              state <= S_COLLECT;
              busy  <= 1'b1;
            end else if (rx_data == CmdStatus) begin
              state <= S_STAT;
            end
          end
        end

        S_STAT: begin
          tx_data <= {st_overrun, st_fragment, st_proto, 5'b0};
          if (spi_cs) begin
            state <= S_IDLE;
          end else if (rx_valid) begin
            // status word has been shifted out during this byte
            st_overrun  <= 1'b0;
            st_fragment <= 1'b0;
            st_proto    <= 1'b0;
            state       <= S_IDLE;
          end
        end

        S_COLLECT: begin
          tx_data <= 8'h00;
          // a byte arriving with cs rising in the same cycle still belongs to the frame
          if (rx_valid) begin
            rec_buf[idx] <= rx_data;
            if (idx == LastIdx) begin
              idx <= '0;
              if (fifo_free_slots != 8'h00) begin
                state         <= S_COMMIT;
                fifo_write_en <= 1'b1;
                fifo_data     <= rec_buf[0];
                wr_idx        <= WrW'(1);
                cs_pend       <= spi_cs;
              end else begin
                st_overrun <= 1'b1;
                if (overrun_count != '1) overrun_count <= overrun_count + CountWidth'(1);
                if (spi_cs) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end
            end else if (spi_cs) begin
              st_fragment <= 1'b1;
              idx         <= '0;
              state       <= S_IDLE;
              busy        <= 1'b0;
            end else begin
              idx <= idx + IdxW'(1);
            end
          end else if (spi_cs) begin
            if (idx != '0) st_fragment <= 1'b1;
            idx   <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_COMMIT: begin
          tx_data <= 8'h00;
          if (rx_valid && !spi_cs) st_proto <= 1'b1;
          if (wr_idx == RecLen) begin
            idx <= '0;
            if (cs_pend || spi_cs) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= S_COLLECT;
            end
          end else begin
            fifo_write_en <= 1'b1;
            fifo_data     <= rec_buf[wr_idx[IdxW-1:0]];
            wr_idx        <= wr_idx + WrW'(1);
            cs_pend       <= cs_pend | spi_cs;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Directed bench for spi_command_sequencer with hand-computed expectations.
module tb_spi_command_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_cs;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic [7:0] fifo_free_slots;
  logic       fifo_write_en;
  logic [7:0] fifo_data;
  logic [7:0] overrun_count;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  int unsigned t_last = 0;
  logic [7:0]  wq[$];
  int unsigned wc[$];

  spi_command_sequencer #(.RecordWords(4), .CountWidth(8)) dut (
    .clk(clk), .rst(rst), .spi_cs(spi_cs), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .fifo_free_slots(fifo_free_slots), .fifo_write_en(fifo_write_en),
    .fifo_data(fifo_data), .overrun_count(overrun_count), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every write strobe with the cycle it was seen in
  always @(negedge clk) begin
    if (fifo_write_en === 1'b1) begin
      wq.push_back(fifo_data);
      wc.push_back(cyc);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t_last   = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  task automatic begin_frame();
    @(negedge clk);
    spi_cs = 1'b0;
    @(negedge clk);
  endtask

  task automatic end_frame();
    @(negedge clk);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_cs = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; fifo_free_slots = 8'd16;
    repeat (2) @(negedge clk);
    tests++;
    if ({fifo_write_en, fifo_data, tx_data, overrun_count, busy} !== 26'h0) begin
      fails++;
      $display("FAIL reset_outputs: got en=%b data=%h tx=%h ovr=%0d busy=%b, want all zero",
               fifo_write_en, fifo_data, tx_data, overrun_count, busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (tx_data !== 8'd16) begin
      fails++; $display("FAIL idle_tx_free: got %h want 10", tx_data);
    end
  endtask

  task automatic test_two_records();
    logic [7:0] exp_d [8];
    int unsigned exp_c [8];
    int unsigned ta, tb;
    fifo_free_slots = 8'd16;
    wq.delete(); wc.delete();
    begin_frame();
    send_byte(8'h02);
    tests++;
    if (busy !== 1'b1 || tx_data !== 8'h00) begin
      fails++; $display("FAIL collect_busy: got busy=%b tx=%h want 1/00", busy, tx_data);
    end
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    ta = t_last;
    for (int i = 0; i < 4; i++) send_byte(8'hB0 + 8'(i));
    tb = t_last;
    end_frame();
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = 8'hA0 + 8'(i);   exp_c[i] = ta + 1 + i;
      exp_d[i+4] = 8'hB0 + 8'(i); exp_c[i+4] = tb + 1 + i;
    end
    tests++;
    if (wq.size() != 8) begin
      fails++; $display("FAIL two_rec_count: got %0d strobes want 8", wq.size());
    end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      tests++;
      if (wq[i] !== exp_d[i] || wc[i] != exp_c[i]) begin
        fails++;
        $display("FAIL two_rec_strobe%0d: got %h@%0d want %h@%0d", i, wq[i], wc[i], exp_d[i], exp_c[i]);
      end
    end
    tests++;
    if (busy !== 1'b0 || tx_data !== 8'd16) begin
      fails++; $display("FAIL two_rec_idle: got busy=%b tx=%h want 0/10", busy, tx_data);
    end
  endtask

  task automatic test_overrun();
    fifo_free_slots = 8'd0;
    wq.delete(); wc.delete();
    begin_frame();
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h11 + 8'(i));
    end_frame();
    tests++;
    if (wq.size() != 0 || overrun_count !== 8'd1) begin
      fails++; $display("FAIL overrun: got strobes=%0d ovr=%0d want 0/1", wq.size(), overrun_count);
    end
    fifo_free_slots = 8'd16;
    begin_frame();
    send_byte(8'h01);
    tests++;
    if (tx_data !== 8'h80) begin
      fails++; $display("FAIL status_overrun: got %h want 80", tx_data);
    end
    send_byte(8'h00);
    end_frame();
    begin_frame();
    send_byte(8'h01);
    tests++;
    if (tx_data !== 8'h00) begin
      fails++; $display("FAIL status_cleared: got %h want 00", tx_data);
    end
    send_byte(8'h00);
    end_frame();
  endtask

  task automatic test_fragment();
    fifo_free_slots = 8'd16;
    wq.delete(); wc.delete();
    begin_frame();
    send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
    end_frame();
    tests++;
    if (wq.size() != 0 || busy !== 1'b0 || tx_data !== 8'd16) begin
      fails++;
      $display("FAIL fragment_drop: got strobes=%0d busy=%b tx=%h want 0/0/10", wq.size(), busy, tx_data);
    end
    begin_frame();
    send_byte(8'h01);
    tests++;
    if (tx_data !== 8'h40) begin
      fails++; $display("FAIL status_fragment: got %h want 40", tx_data);
    end
    send_byte(8'h00);
    end_frame();
    begin_frame();
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'h31 + 8'(i));
    end_frame();
    tests++;
    if (wq.size() != 4) begin
      fails++; $display("FAIL after_frag_count: got %0d want 4", wq.size());
    end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      tests++;
      if (wq[i] !== 8'h31 + 8'(i)) begin
        fails++; $display("FAIL after_frag_data%0d: got %h want %h", i, wq[i], 8'h31 + 8'(i));
      end
    end
  endtask

  task automatic test_cs_same_cycle();
    int unsigned t;
    wq.delete(); wc.delete();
    begin_frame();
    send_byte(8'h02); send_byte(8'h41); send_byte(8'h42); send_byte(8'h43);
    @(negedge clk);
    rx_data = 8'h44; rx_valid = 1'b1; spi_cs = 1'b1; t = cyc;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (7) @(negedge clk);
    tests++;
    if (wq.size() != 4 || busy !== 1'b0) begin
      fails++; $display("FAIL cs_same_count: got strobes=%0d busy=%b want 4/0", wq.size(), busy);
    end
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      tests++;
      if (wq[i] !== 8'h41 + 8'(i) || wc[i] != t + 1 + i) begin
        fails++;
        $display("FAIL cs_same_strobe%0d: got %h@%0d want %h@%0d", i, wq[i], wc[i], 8'h41 + 8'(i), t + 1 + i);
      end
    end
    begin_frame();
    send_byte(8'h01);
    tests++;
    if (tx_data !== 8'h00) begin
      fails++; $display("FAIL cs_same_status: got %h want 00", tx_data);
    end
    send_byte(8'h00);
    end_frame();
  endtask

  task automatic test_noop();
    fifo_free_slots = 8'd7;
    wq.delete(); wc.delete();
    repeat (2) @(negedge clk);
    tests++;
    if (tx_data !== 8'h07) begin
      fails++; $display("FAIL idle_tx7: got %h want 07", tx_data);
    end
    begin_frame();
    send_byte(8'h05);
    tests++;
    if (tx_data !== 8'h07 || busy !== 1'b0) begin
      fails++; $display("FAIL unknown_cmd: got tx=%h busy=%b want 07/0", tx_data, busy);
    end
    end_frame();
    tests++;
    if (wq.size() != 0) begin
      fails++; $display("FAIL unknown_cmd_writes: got %0d want 0", wq.size());
    end
  endtask

  task automatic test_reset_mid_commit();
    int unsigned sz;
    fifo_free_slots = 8'd16;
    wq.delete(); wc.delete();
    begin_frame();
    send_byte(8'h02); send_byte(8'h51); send_byte(8'h52); send_byte(8'h53);
    @(negedge clk);
    rx_data = 8'h54; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (fifo_write_en !== 1'b1 || fifo_data !== 8'h52) begin
      fails++; $display("FAIL second_strobe: got en=%b data=%h want 1/52", fifo_write_en, fifo_data);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (fifo_write_en !== 1'b0 || busy !== 1'b0 || overrun_count !== 8'd0 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_commit: got en=%b busy=%b ovr=%0d tx=%h want 0/0/0/00",
               fifo_write_en, busy, overrun_count, tx_data);
    end
    spi_cs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sz = wq.size();
    repeat (6) @(negedge clk);
    tests++;
    if (wq.size() != sz || tx_data !== 8'd16 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_idle: got extra=%0d tx=%h busy=%b want 0/10/0", wq.size() - sz, tx_data, busy);
    end
  endtask

  initial begin
    test_reset();
    test_two_records();
    test_overrun();
    test_fragment();
    test_cs_same_cycle();
    test_noop();
    test_reset_mid_commit();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
